// File: rtl/scoreboard_stall_ctrl.sv
// Issue controller for a non-forwarding 5-stage RV32I pipeline: per-register
// countdown scoreboard, hazard stall, branch flush, drain/halt FSM, perf counters.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_*_i                  decoded operands of the instruction held in ID
//   ex_br_taken_i           EX redirects the PC this cycle
//   drain_req_i             level request to stop issue and empty the pipe
//   pc_enable_o/id_enable_o PC and IF/ID enables
//   id_reset_no/ex_reset_no active-low flush of IF/ID and ID/EX
//   issue_o                 ID instruction moves into EX this cycle
//   drain_ack_o             pipeline empty and halted
//   sb_busy_o               per-register pending-write flags
//   stall_cnt_o/flush_cnt_o saturating RAW-stall and flush counters
module scoreboard_stall_ctrl #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_is_rs1_i,
    input  logic             id_is_rs2_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wren_i,
    input  logic             ex_br_taken_i,
    input  logic             drain_req_i,
    output logic             pc_enable_o,
    output logic             id_enable_o,
    output logic             id_reset_no,
    output logic             ex_reset_no,
    output logic             issue_o,
    output logic             drain_ack_o,
    output logic [31:0]      sb_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int SW = $clog2(WB_LAT + 1);
    localparam logic [SW-1:0] LAT = SW'(WB_LAT);
    localparam logic [SW-1:0] SB_ONE = SW'(1);
    localparam logic [CNT_W-1:0] PC_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           r_state;
    logic             r_ack;
    logic [SW-1:0]    r_cnt [1:31];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0] w_busy;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_hazard;
    logic        w_empty;
    logic        w_issue;
    logic        w_stall;

    // x0 never has a pending write.
    always_comb begin
        w_busy = '0;
        for (int r = 1; r < 32; r++) begin
            w_busy[r] = (r_cnt[r] != '0);
        end
    end

    assign w_rs1_hit = id_is_rs1_i && (id_rs1_addr_i != 5'd0)
                       && w_busy[id_rs1_addr_i];
    assign w_rs2_hit = id_is_rs2_i && (id_rs2_addr_i != 5'd0)
                       && w_busy[id_rs2_addr_i];
    assign w_hazard  = id_valid_i && (w_rs1_hit || w_rs2_hit);
    assign w_empty   = (w_busy == 32'd0);

    // Flush beats drain/halt bubbles, which beat RAW stalls.
    always_comb begin
        pc_enable_o = 1'b1;
        id_enable_o = 1'b1;
        id_reset_no = 1'b1;
        ex_reset_no = 1'b1;
        w_issue     = id_valid_i;
        w_stall     = 1'b0;
        if (ex_br_taken_i) begin
            id_reset_no = 1'b0;
            ex_reset_no = 1'b0;
            w_issue     = 1'b0;
        end else if (r_state != S_IDLE) begin
            pc_enable_o = 1'b0;
            id_enable_o = 1'b0;
            ex_reset_no = 1'b0;
            w_issue     = 1'b0;
        end else if (w_hazard) begin
            pc_enable_o = 1'b0;
            id_enable_o = 1'b0;
            ex_reset_no = 1'b0;
            w_issue     = 1'b0;
            w_stall     = 1'b1;
        end
    end

    // A new write to rd reloads the full latency even if still busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 1; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_issue && id_rd_wren_i && (id_rd_addr_i == 5'(r))) begin
                    r_cnt[r] <= LAT;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - SB_ONE;
                end
            end
        end
    end

    // Halt only once the scoreboard is empty and no redirect is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (drain_req_i) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!drain_req_i) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end else if (w_empty && !ex_br_taken_i) begin
                        r_state <= S_HALTED;
                        r_ack   <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!drain_req_i) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PC_ONE;
            end
            if (ex_br_taken_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PC_ONE;
            end
        end
    end

    assign issue_o     = w_issue;
    assign drain_ack_o = r_ack;
    assign sb_busy_o   = w_busy;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
